mod_writeback_stage: RTL
========================

MOD_WRITEBACK_STAGE -- requirements
Module: mod_writeback_stage

Interface
REQ-001 Parameter: DRAIN_CYCLES, 2, cycles between halt retirement and dump_all pulse; legal range 1..15.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous reset, active-low.
REQ-004 hold  in  1  pipeline stall; when 1, the WB register holds and the write port is suppressed.
REQ-005 in_valid, in_reg_write, in_mem_to_reg, in_halt  in  1 each  MEM-stage instruction valid, writes rd, result from memory, halt instruction.
REQ-006 in_pc  in  32  and  in_alu_result  in  32  and  in_rd  in  5  and  in_addr_lo  in  2  MEM-stage fields.
REQ-007 in_load_type  in  3  load type: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; 101-111 treated as word.
REQ-008 mem_read_data  in  32  data memory read word, valid in the cycle the load occupies the WB register.
REQ-009 write_address  out  5,  write_data  out  32,  write  out  1  register-file write port.
REQ-010 fwd_valid  out  1,  fwd_address  out  5,  fwd_data  out  32  WB-to-decode bypass.
REQ-011 pc  out  32,  dump_all  out  1,  halted  out  1  architectural-dump control.
REQ-012 retire_count  out  32  count of retired instructions.

Function
REQ-013 WB register: when hold=0, it captures all in_* fields on each edge; when hold=1, it retains its contents.
REQ-014 write = wb_valid & wb_reg_write & (wb_rd != 0) & ~hold & (state == RUN); write_address = wb_rd; all three are combinational from the WB register.
REQ-015 write_data = wb_alu_result when wb_mem_to_reg=0, otherwise the extracted load value.
REQ-016 Byte extraction: byte k = mem_read_data[8k+7:8k] with k = wb_addr_lo (little-endian); the byte is sign- or zero-extended to 32 bits per load type.
REQ-017 Half extraction: upper half when wb_addr_lo[1]=1, else lower half; wb_addr_lo[0] is ignored; the half is sign- or zero-extended per load type.
REQ-018 Word loads pass mem_read_data unchanged; no alignment trap is raised.
REQ-019 fwd_valid = write; fwd_address = write_address; fwd_data = write_data; all combinational, for a same-cycle decode read.
REQ-020 FSM states: RUN, DRAIN, DUMP, HALTED.
REQ-021 RUN -> DRAIN when wb_valid & wb_halt & ~hold; the halt pc is latched and the drain counter is loaded with DRAIN_CYCLES.
REQ-022 The halt instruction itself performs no register write, even if in_reg_write=1.
REQ-023 DRAIN: the drain counter decrements on each edge with hold=0; DRAIN -> DUMP on the edge where the counter reaches 0.
REQ-024 DUMP: dump_all=1 for exactly one cycle, then the FSM moves to HALTED.
REQ-025 HALTED: write=0 and halted=1; the FSM leaves HALTED only on reset.
REQ-026 In DRAIN, DUMP and HALTED, write=0 regardless of WB register contents, so younger instructions never commit.
REQ-027 pc = wb_pc in RUN; pc = latched halt pc in DRAIN, DUMP and HALTED.
REQ-028 retire_count increments on each edge where wb_valid & ~hold & (state == RUN); the halt counts as retired; the counter wraps from 0xFFFFFFFF to 0.
REQ-029 hold and halt in the same cycle: no transition; the transition occurs on the first cycle with hold=0.

Reset
REQ-030 reset=0 at an edge clears wb_valid and all WB fields to 0, sets state to RUN, and clears the drain counter, latched pc and retire_count.
REQ-031 After reset: write, fwd_valid, dump_all and halted are 0; write_address, write_data, pc and retire_count are 0.
REQ-032 Reset overrides hold and aborts any state, including DRAIN and DUMP, mid-sequence.

Configuration
REQ-033 With macro WB_RETIRE_COUNT_EN defined, the retire counter per REQ-028 is compiled in.
REQ-034 With WB_RETIRE_COUNT_EN undefined, no counter is built and retire_count is tied to 32'h0; all other behaviour is identical.

Verification
REQ-035 ALU write: rd=5, alu=0x1234, reg_write=1 -> next cycle write=1, address=5, data=0x1234, fwd_valid=1.
REQ-036 Loads with mem_read_data=0x80FF7F01: lb addr_lo=3 -> 0xFFFFFF80; lbu addr_lo=1 -> 0x7F; lh addr_lo=2 -> 0xFFFF80FF; lhu addr_lo=0 -> 0x7F01.
REQ-037 rd=0 with reg_write=1 -> write=0 and fwd_valid=0; hold=1 with a valid write -> write=0, and the write fires once after hold drops.
REQ-038 Halt at pc=0x40 with DRAIN_CYCLES=2 and no hold -> state DRAIN for 2 cycles, then one dump_all=1 cycle with pc=0x40, then halted=1; no write after the halt.
REQ-039 Reset=0 asserted during DRAIN -> next cycle state RUN, dump_all never asserts, retire_count=0.
REQ-040 WB_RETIRE_COUNT_EN defined: 10 valid instructions including 2 held cycles -> retire_count=10; counter preloaded to 0xFFFFFFFF plus 1 retire -> 0; macro undefined -> retire_count stays 0.

Source files
------------

// File: rtl/mod_writeback_stage.sv
// Writeback stage: load extraction, register-file write/bypass, halt drain/dump FSM; write is combinational from the WB register, hold stalls it.
// Optional retired-instruction counter is compiled in with WB_RETIRE_COUNT_EN.
module mod_writeback_stage #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        in_valid,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic        in_halt,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_result,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_addr_lo,
  input  logic [2:0]  in_load_type,
  input  logic [31:0] mem_read_data,
  output logic [4:0]  write_address,
  output logic [31:0] write_data,
  output logic        write,
  output logic        fwd_valid,
  output logic [4:0]  fwd_address,
  output logic [31:0] fwd_data,
  output logic [31:0] pc,
  output logic        dump_all,
  output logic        halted,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {RUN, DRAIN, DUMP, HALTED} state_t;

  localparam logic [3:0] LP_DRAIN = 4'(DRAIN_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_drain_cnt;
  logic [31:0] r_halt_pc;

  logic        r_wb_valid, r_wb_reg_write, r_wb_mem_to_reg, r_wb_halt;
  logic [31:0] r_wb_pc, r_wb_alu_result;
  logic [4:0]  r_wb_rd;
  logic [1:0]  r_wb_addr_lo;
  logic [2:0]  r_wb_load_type;

  logic        w_run, w_halt_take, w_dump;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_halt       <= 1'b0;
      r_wb_pc         <= '0;
      r_wb_alu_result <= '0;
      r_wb_rd         <= '0;
      r_wb_addr_lo    <= '0;
      r_wb_load_type  <= '0;
    end else if (!hold) begin
      r_wb_valid      <= in_valid;
      r_wb_reg_write  <= in_reg_write;
      r_wb_mem_to_reg <= in_mem_to_reg;
      r_wb_halt       <= in_halt;
      r_wb_pc         <= in_pc;
      r_wb_alu_result <= in_alu_result;
      r_wb_rd         <= in_rd;
      r_wb_addr_lo    <= in_addr_lo;
      r_wb_load_type  <= in_load_type;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_halt_take = 1'b0;
    w_dump      = 1'b0;
    case (r_state)
      RUN: begin
        w_run       = 1'b1;
        w_halt_take = r_wb_valid & r_wb_halt & ~hold;
        if (w_halt_take) w_state_nxt = DRAIN;
      end
      // Leave on the edge that takes the counter from 1 to 0.
      DRAIN:   if (!hold && r_drain_cnt <= 4'd1) w_state_nxt = DUMP;
      DUMP: begin
        w_dump      = 1'b1;
        w_state_nxt = HALTED;
      end
      default: w_state_nxt = HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_drain_cnt <= '0;
      r_halt_pc   <= '0;
    end else if (w_halt_take) begin
      r_drain_cnt <= LP_DRAIN;
      r_halt_pc   <= r_wb_pc;
    end else if (r_state == DRAIN && !hold) begin
      r_drain_cnt <= r_drain_cnt - 4'd1;
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_wb_addr_lo)
      2'd0:    w_byte = mem_read_data[7:0];
      2'd1:    w_byte = mem_read_data[15:8];
      2'd2:    w_byte = mem_read_data[23:16];
      default: w_byte = mem_read_data[31:24];
    endcase
    w_half = r_wb_addr_lo[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (r_wb_load_type)
      3'b001:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_load_val = {24'h0, w_byte};
      3'b011:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {16'h0, w_half};
      default: w_load_val = mem_read_data;
    endcase
  end

  // The halt itself never writes, even when it carries reg_write.
  assign write         = r_wb_valid & r_wb_reg_write & ~r_wb_halt & (r_wb_rd != 5'd0) & ~hold & w_run;
  assign write_address = r_wb_rd;
  assign write_data    = r_wb_mem_to_reg ? w_load_val : r_wb_alu_result;
  assign fwd_valid     = write;
  assign fwd_address   = write_address;
  assign fwd_data      = write_data;
  assign pc            = w_run ? r_wb_pc : r_halt_pc;
  assign dump_all      = w_dump;
  assign halted        = (r_state == HALTED);

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] r_retire_cnt;
  always_ff @(posedge clk) begin
    if (!reset)                            r_retire_cnt <= '0;
    else if (r_wb_valid && !hold && w_run) r_retire_cnt <= r_retire_cnt + 32'd1;
  end
  assign retire_count = r_retire_cnt;
`else
  assign retire_count = 32'h0;
`endif

endmodule
